// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode encodings, field widths and
// small helpers used by the mode controller and the display scanner.
package clock_pkg;

    localparam int unsigned HOUR_W     = 5;
    localparam int unsigned MINSEC_W   = 6;
    localparam int unsigned HOUR_MAX   = 23;
    localparam int unsigned MINSEC_MAX = 59;
    localparam int unsigned MODE_W     = 3;

    typedef enum logic [MODE_W-1:0] {
        S_NORMAL  = 3'd0,
        S_ADJ_H   = 3'd1,
        S_ADJ_M   = 3'd2,
        S_ALARM_H = 3'd3,
        S_ALARM_M = 3'd4
    } mode_e;

    // Mode sequence advanced by the mode button.
    function automatic mode_e mode_advance(input mode_e m);
        mode_e r;
        if (m == S_ALARM_M) begin
            r = S_NORMAL;
        end else begin
            r = mode_e'(MODE_W'(m) + MODE_W'(1));
        end
        return r;
    endfunction

    // Value a modulo counter holds after one clock, given its strobes.
    function automatic logic [MINSEC_W-1:0] mod_step(
        input logic [MINSEC_W-1:0] v,
        input logic                inc,
        input logic                clr,
        input logic [MINSEC_W-1:0] max_v
    );
        logic [MINSEC_W-1:0] r;
        r = v;
        if (clr) begin
            r = '0;
        end else if (inc) begin
            r = (v == max_v) ? '0 : v + MINSEC_W'(1);
        end
        return r;
    endfunction

    // Alarm-setting modes show the alarm registers instead of the time.
    function automatic logic is_alarm_view(input mode_e m);
        return (m == S_ALARM_H) || (m == S_ALARM_M);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear; wrap flags the increment
// that rolls MOD-1 back to zero so it can carry into the next field.
module mod_counter #(
    parameter int unsigned MOD  = 60,
    parameter int unsigned W    = 6,
    parameter int unsigned INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = inc && !clr && (value == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= W'(INIT);
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode controller and timekeeper: sequences normal / adjust / alarm-set modes,
// keeps time-of-day and alarm registers, and drives the display and alarm.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S    = 30,
    parameter int unsigned RING_S       = 60,
    parameter int unsigned ALARM_H_INIT = 6,
    parameter int unsigned ALARM_M_INIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_1hz,
    input  logic                btn_mode,
    input  logic                btn_inc,
    output logic [HOUR_W-1:0]   hour,
    output logic [MINSEC_W-1:0] min,
    output logic [MINSEC_W-1:0] sec,
    output logic [MODE_W-1:0]   display_mode,
    output logic                alarm_armed,
    output logic                alarm_ring
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam int unsigned RING_W = $clog2(RING_S + 1);

    mode_e state_q;
    mode_e state_d;

    logic btn_any;
    logic silence;
    logic mode_req;
    logic inc_req;
    logic timeout;

    logic time_run;
    logic sec_clr;
    logic adj_h_inc;
    logic adj_m_inc;
    logic ah_inc;
    logic am_inc;
    logic arm_tgl;

    logic sec_inc;
    logic min_inc;
    logic hour_inc;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap_unused;
    logic ah_wrap_unused;
    logic am_wrap_unused;

    logic [MINSEC_W-1:0] sec_q;
    logic [MINSEC_W-1:0] min_q;
    logic [HOUR_W-1:0]   hour_q;
    logic [HOUR_W-1:0]   ah_q;
    logic [MINSEC_W-1:0] am_q;

    logic [MINSEC_W-1:0] sec_nx;
    logic [MINSEC_W-1:0] min_nx;
    logic [HOUR_W-1:0]   hour_nx;
    logic [HOUR_W-1:0]   ah_nx;
    logic [MINSEC_W-1:0] am_nx;

    logic [IDLE_W-1:0]   idle_q;
    logic [RING_W-1:0]   ring_cnt_q;
    logic                tick_upd_q;
    logic                armed_q;
    logic                ring_q;
    logic                ring_match;
    logic                ring_clear;

    logic [HOUR_W-1:0]   disp_hour_q;
    logic [MINSEC_W-1:0] disp_min_q;
    logic [MINSEC_W-1:0] disp_sec_q;

    // A button pressed while ringing only silences; mode beats inc.
    assign btn_any  = btn_mode || btn_inc;
    assign silence  = ring_q && btn_any;
    assign mode_req = btn_mode && !silence;
    assign inc_req  = btn_inc && !btn_mode && !silence;
    assign timeout  = (state_q != S_NORMAL) && tick_1hz && !btn_any &&
                      (idle_q == IDLE_W'(TIMEOUT_S - 1));

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-mode selection.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_NORMAL;
        end else if (mode_req) begin
            state_d = mode_advance(state_q);
        end
    end

    // Per-mode control strobes.
    always_comb begin
        time_run  = 1'b0;
        sec_clr   = 1'b0;
        adj_h_inc = 1'b0;
        adj_m_inc = 1'b0;
        ah_inc    = 1'b0;
        am_inc    = 1'b0;
        arm_tgl   = 1'b0;
        unique case (state_q)
            S_NORMAL: begin
                time_run = 1'b1;
                arm_tgl  = inc_req;
            end
            S_ADJ_H: begin
                adj_h_inc = inc_req;
            end
            S_ADJ_M: begin
                adj_m_inc = inc_req;
                sec_clr   = (state_d != S_ADJ_M);
            end
            S_ALARM_H: begin
                time_run = 1'b1;
                ah_inc   = inc_req;
            end
            S_ALARM_M: begin
                time_run = 1'b1;
                am_inc   = inc_req;
            end
            default: ;
        endcase
    end

    // Carry chain; a manual minute wrap never reaches the hour.
    assign sec_inc  = tick_1hz && time_run;
    assign min_inc  = sec_wrap || adj_m_inc;
    assign hour_inc = (min_wrap && time_run) || adj_h_inc;

    mod_counter #(.MOD(MINSEC_MAX + 1), .W(MINSEC_W), .INIT(0)) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .value (sec_q),
        .wrap  (sec_wrap)
    );

    mod_counter #(.MOD(MINSEC_MAX + 1), .W(MINSEC_W), .INIT(0)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (min_q),
        .wrap  (min_wrap)
    );

    mod_counter #(.MOD(HOUR_MAX + 1), .W(HOUR_W), .INIT(0)) u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hour_inc),
        .clr   (1'b0),
        .value (hour_q),
        .wrap  (hour_wrap_unused)
    );

    mod_counter #(.MOD(HOUR_MAX + 1), .W(HOUR_W), .INIT(ALARM_H_INIT)) u_alarm_h (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ah_inc),
        .clr   (1'b0),
        .value (ah_q),
        .wrap  (ah_wrap_unused)
    );

    mod_counter #(.MOD(MINSEC_MAX + 1), .W(MINSEC_W), .INIT(ALARM_M_INIT)) u_alarm_m (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (am_inc),
        .clr   (1'b0),
        .value (am_q),
        .wrap  (am_wrap_unused)
    );

    // Post-edge counter values so the display register shows them with latency 1.
    assign sec_nx  = mod_step(sec_q, sec_inc, sec_clr, MINSEC_W'(MINSEC_MAX));
    assign min_nx  = mod_step(min_q, min_inc, 1'b0, MINSEC_W'(MINSEC_MAX));
    assign hour_nx = HOUR_W'(mod_step(MINSEC_W'(hour_q), hour_inc, 1'b0,
                                      MINSEC_W'(HOUR_MAX)));
    assign ah_nx   = HOUR_W'(mod_step(MINSEC_W'(ah_q), ah_inc, 1'b0,
                                      MINSEC_W'(HOUR_MAX)));
    assign am_nx   = mod_step(am_q, am_inc, 1'b0, MINSEC_W'(MINSEC_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_hour_q <= '0;
            disp_min_q  <= '0;
            disp_sec_q  <= '0;
        end else if (is_alarm_view(state_d)) begin
            disp_hour_q <= ah_nx;
            disp_min_q  <= am_nx;
            disp_sec_q  <= '0;
        end else begin
            disp_hour_q <= hour_nx;
            disp_min_q  <= min_nx;
            disp_sec_q  <= sec_nx;
        end
    end

    // Idle seconds spent outside normal mode; any button or mode change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if ((state_q == S_NORMAL) || btn_any || (state_d != state_q)) begin
            idle_q <= '0;
        end else if (tick_1hz) begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end

    // Only a tick-driven update may trigger; compared one cycle after it lands.
    assign ring_match = tick_upd_q && armed_q && (hour_q == ah_q) &&
                        (min_q == am_q) && (sec_q == '0);
    assign ring_clear = btn_any || (arm_tgl && armed_q) ||
                        (tick_1hz && (ring_cnt_q == RING_W'(RING_S - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_upd_q <= 1'b0;
            armed_q    <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            tick_upd_q <= sec_inc;
            if (arm_tgl) begin
                armed_q <= !armed_q;
            end
            if (ring_q) begin
                if (ring_clear) begin
                    ring_q     <= 1'b0;
                    ring_cnt_q <= '0;
                end else if (tick_1hz) begin
                    ring_cnt_q <= ring_cnt_q + RING_W'(1);
                end
            end else begin
                ring_cnt_q <= '0;
                ring_q     <= ring_match && !arm_tgl;
            end
        end
    end

    assign hour         = disp_hour_q;
    assign min          = disp_min_q;
    assign sec          = disp_sec_q;
    assign display_mode = state_q;
    assign alarm_armed  = armed_q;
    assign alarm_ring   = ring_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: timekeeping, mode sequencing, adjust,
// alarm trigger/silence/duration, idle timeout and asynchronous reset.
module tb_clock_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [2:0] display_mode;
    logic       alarm_armed;
    logic       alarm_ring;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clock_mode_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .hour         (hour),
        .min          (min),
        .sec          (sec),
        .display_mode (display_mode),
        .alarm_armed  (alarm_armed),
        .alarm_ring   (alarm_ring)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, int'(hour), h);
        check({tag, ".min"}, int'(min), m);
        check({tag, ".sec"}, int'(sec), s);
    endtask

    // One clock with the given pulses; outputs sampled 1 ns after the edge.
    task automatic cyc(input logic t, input logic m, input logic i);
        @(negedge clk);
        tick_1hz = t;
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press_mode(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press_inc(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From reset: adjust to 05:59, return to normal, tick up to 05:59:59.
    task automatic set_0559();
        press_mode(1);
        press_inc(5);
        press_mode(1);
        press_inc(59);
        press_mode(3);
        ticks(59);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        #1;
        check_time("reset", 0, 0, 0);
        check("reset.mode", int'(display_mode), 0);
        check("reset.armed", int'(alarm_armed), 0);
        check("reset.ring", int'(alarm_ring), 0);

        ticks(3661);
        check_time("t3661", 1, 1, 1);
        check("t3661.mode", int'(display_mode), 0);
        check("t3661.ring", int'(alarm_ring), 0);

        // Set 23:59 by hand, check wraps and the alarm view on the way.
        do_reset();
        press_mode(1);
        check("adjh.mode", int'(display_mode), 1);
        press_inc(23);
        check("adjh.hour23", int'(hour), 23);
        press_mode(1);
        check("adjm.mode", int'(display_mode), 2);
        press_inc(59);
        check("adjm.min59", int'(min), 59);
        press_inc(1);
        check_time("adjm.wrap", 23, 0, 0);
        press_inc(59);
        press_mode(1);
        check("alarmh.mode", int'(display_mode), 3);
        check_time("alarmh.view", 6, 0, 0);
        press_mode(1);
        check("alarmm.mode", int'(display_mode), 4);
        press_mode(1);
        check("normal.mode", int'(display_mode), 0);
        check_time("normal.2359", 23, 59, 0);
        ticks(59);
        check_time("t235959", 23, 59, 59);
        ticks(1);
        check_time("daywrap", 0, 0, 0);

        // Seconds survive adjust-hour, are frozen there, and clear leaving adjust-minute.
        ticks(37);
        check("sec37", int'(sec), 37);
        press_mode(1);
        ticks(3);
        check_time("adjh.frozen", 0, 0, 37);
        press_mode(1);
        check("secclr.adjm", int'(display_mode), 2);
        press_mode(3);
        check("secclr.mode", int'(display_mode), 0);
        check_time("secclr", 0, 0, 0);

        // Alarm trigger at 06:00:00, latency two from the tick, silenced by mode button.
        do_reset();
        set_0559();
        check_time("t055959", 5, 59, 59);
        press_inc(1);
        check("arm", int'(alarm_armed), 1);
        cyc(1'b1, 1'b0, 1'b0);
        check_time("t060000", 6, 0, 0);
        check("ring.lat1", int'(alarm_ring), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("ring.lat2", int'(alarm_ring), 1);
        cyc(1'b0, 1'b1, 1'b0);
        check("silence.ring", int'(alarm_ring), 0);
        check("silence.mode", int'(display_mode), 0);
        check("silence.armed", int'(alarm_armed), 1);

        // Idle timeout from alarm-hour mode, and a button at tick 29 restarting it.
        press_mode(3);
        check("to.enter", int'(display_mode), 3);
        ticks(29);
        check("to.tick29", int'(display_mode), 3);
        ticks(1);
        check("to.tick30", int'(display_mode), 0);
        press_mode(3);
        ticks(29);
        press_inc(1);
        check("to.alarmh7", int'(hour), 7);
        ticks(1);
        check("to.held", int'(display_mode), 3);

        // Mode and inc together: mode wins, hour untouched.
        do_reset();
        press_mode(1);
        cyc(1'b0, 1'b1, 1'b1);
        check("both.mode", int'(display_mode), 2);
        check_time("both.time", 0, 0, 0);

        // Alarm at 00:01 (alarm hour wraps 23->0), ring, then async reset mid-ring.
        do_reset();
        press_mode(3);
        press_inc(18);
        check("alarmh.wrap", int'(hour), 0);
        press_mode(1);
        press_inc(1);
        check("alarmm.set", int'(min), 1);
        press_mode(1);
        press_inc(1);
        ticks(60);
        check_time("t000100", 0, 1, 0);
        check("ring0001", int'(alarm_ring), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_time("async", 0, 0, 0);
        check("async.mode", int'(display_mode), 0);
        check("async.armed", int'(alarm_armed), 0);
        check("async.ring", int'(alarm_ring), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ring ends by itself on the 60th tick after it starts.
        set_0559();
        press_inc(1);
        ticks(1);
        check("dur.start", int'(alarm_ring), 1);
        ticks(59);
        check("dur.tick59", int'(alarm_ring), 1);
        cyc(1'b1, 1'b0, 1'b0);
        check("dur.tick60", int'(alarm_ring), 0);
        check("dur.armed", int'(alarm_armed), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Mode controller and timekeeper for the digital clock. It sequences the user-interface modes (normal, time adjust, alarm adjust) from debounced button pulses and keeps the time-of-day and alarm registers. It drives the `hour/min/sec/display_mode` inputs of `display_scanner` and raises the alarm output. It sits between the button debouncers and 1 Hz tick generator on one side and the display scanner on the other.

## Interface
- `TIMEOUT_S`, 30: idle seconds in any non-normal mode before automatic return to normal.
- `RING_S`, 60: maximum alarm ring duration, in seconds.
- `ALARM_H_INIT`, 6: alarm hour after reset.
- `ALARM_M_INIT`, 0: alarm minute after reset.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  single-cycle pulse, once per second.
- `btn_mode`  in  1  single-cycle debounced press pulse; advances the mode.
- `btn_inc`  in  1  single-cycle debounced press pulse; increments, arms or silences.
- `hour`  out  5  displayed hour, 0–23.
- `min`  out  6  displayed minute, 0–59.
- `sec`  out  6  displayed second, 0–59.
- `display_mode`  out  3  current mode encoding, sent to the scanner.
- `alarm_armed`  out  1  alarm enabled.
- `alarm_ring`  out  1  alarm sounding.

## Operation
- **Modes:** S_NORMAL=0, S_ADJ_H=1, S_ADJ_M=2, S_ALARM_H=3, S_ALARM_M=4. `btn_mode` cycles 0→1→2→3→4→0.
- **Timekeeping:** on `tick_1hz`, sec increments. 59→0 carries into min; min 59→0 carries into hour; hour 23→0.
  - Ticks advance time in S_NORMAL, S_ALARM_H and S_ALARM_M.
  - In S_ADJ_H and S_ADJ_M, time is frozen and ticks are ignored for timekeeping.
- **`btn_inc` by mode:**
  - S_ADJ_H: time hour +1, wraps 23→0.
  - S_ADJ_M: time min +1, wraps 59→0, no carry into hour.
  - S_ALARM_H: alarm hour +1, wraps 23→0.
  - S_ALARM_M: alarm min +1, wraps 59→0.
  - S_NORMAL: toggles `alarm_armed`.
- **Seconds clear:** leaving S_ADJ_M, by button or by timeout, clears sec to 0.
- **Display mux:**
  - S_ALARM_H and S_ALARM_M: outputs show alarm hour, alarm minute, and sec=0.
  - All other modes: outputs show time.
- **Alarm trigger:** `alarm_ring` sets when a tick-driven time update lands on alarm_h:alarm_m:00 while `alarm_armed`=1.
  - Manual adjustment into a matching time does not trigger.
- **Alarm clear:** `alarm_ring` clears on any button pulse, after `RING_S` ticks, or on disarm.
  - A button pulse that silences the alarm is consumed: no mode change, no increment, no arm toggle.
- **Idle timeout:** an idle counter runs in non-normal modes.
  - It counts ticks, including ticks in the adjust modes, and clears on any button pulse or on mode change.
  - At `TIMEOUT_S` it forces S_NORMAL.
- **Simultaneous events:**
  - `btn_mode` together with `btn_inc`: `btn_mode` wins and `btn_inc` is dropped.
  - `tick_1hz` together with `btn_inc` in S_NORMAL: both take effect.
  - A tick carry together with a timeout exit from S_ADJ_M: sec clears and the tick is ignored.
- **Reset values:**
  - Time 00:00:00.
  - Alarm `ALARM_H_INIT`:`ALARM_M_INIT`.
  - `display_mode`=0, `alarm_armed`=0, `alarm_ring`=0.
  - Idle and ring counters = 0.
- **Reset mid-operation:** returns immediately to the reset values.

## Timing
- All outputs are registered.
- `display_mode`, `hour/min/sec` and `alarm_armed` reflect a pulse or tick at the first rising edge after it is sampled (latency 1).
- `alarm_ring` rises one cycle after `hour/min/sec` first show the matching value (latency 2 from the tick).
- `alarm_ring` falls 1 cycle after the clearing pulse or tick.
- Timeout: mode returns to 0 one cycle after the `TIMEOUT_S`-th idle tick.
- Input pulses are assumed ≥1 cycle apart per input. No handshake; pulses are never queued.

## Structure
- Shared package `clock_pkg`:
  - mode encodings S_NORMAL..S_ALARM_M, also used by `display_scanner`.
  - `HOUR_W=5`, `MINSEC_W=6`, `HOUR_MAX=23`, `MINSEC_MAX=59`.
- Sub-module `mod_counter` (params `MOD`, `W`; inputs `inc`, `clr`; outputs `value`, `wrap`).
  - Instantiated for sec, min, hour, alarm hour and alarm minute.
- The top level holds the mode FSM, idle/ring counters, alarm compare and display mux.

## Test plan
- Reset, then 3661 ticks → 01:01:01, `display_mode`=0, `alarm_ring`=0.
- Time 23:59:59 + one tick → 00:00:00. Separately: S_ADJ_M at min=59, `btn_inc` → min=0, hour unchanged.
- Five `btn_mode` pulses → `display_mode` 1,2,3,4,0. Leaving S_ADJ_M with sec=37 → sec=0. Ticks in S_ADJ_H leave time unchanged.
- Alarm 06:00, armed, time 05:59:59 + tick → `alarm_ring`=1 two cycles after the tick. `btn_mode` pulse → ring=0 and `display_mode` stays 0.
- Enter S_ALARM_H, no buttons for 30 ticks → `display_mode`=0. The same flow with `btn_inc` at tick 29 remains in S_ALARM_H.
- `btn_mode`+`btn_inc` together in S_ADJ_H → mode 2, hour unchanged. Assert `rst_n` low mid-ring → all outputs at reset values asynchronously.
